// File: rtl/fetch_stage.sv
// IF stage of the RV32I pipeline: owns the PC, fetches from combinational imem and fills IF/ID.
// Optional performance counters (fetch/stall/flush) are enabled with `define FETCH_PERF_CNT_EN.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter int          CNT_W     = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall_i,
    input  logic              redirect_i,
    input  logic [31:0]       redirect_target_i,
    output logic [31:0]       imem_addr_o,
    input  logic [31:0]       imem_instr_i,
    output logic [31:0]       if_id_pc_o,
    output logic [31:0]       if_id_pc4_o,
    output logic [31:0]       if_id_instr_o,
    output logic              if_id_valid_o,
    output logic              misalign_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  perf_fetch_o,
    output logic [CNT_W-1:0]  perf_stall_o,
    output logic [CNT_W-1:0]  perf_flush_o
`endif
);

    // Only the word index is stored, so pc[1:0] is zero by construction.
    logic [29:0] pc_word;
    logic [31:0] pc_plus4;

    assign imem_addr_o = {pc_word, 2'b00};
    assign pc_plus4    = {pc_word + 30'd1, 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_word       <= RESET_PC[31:2];
            if_id_pc_o    <= 32'h0;
            if_id_pc4_o   <= 32'h0;
            if_id_instr_o <= NOP_INSTR;
            if_id_valid_o <= 1'b0;
            misalign_o    <= 1'b0;
        end else if (redirect_i) begin
            // Redirect beats stall: the stalled fetch is younger than the branch.
            pc_word       <= redirect_target_i[31:2];
            if_id_instr_o <= NOP_INSTR;
            if_id_valid_o <= 1'b0;
            misalign_o    <= |redirect_target_i[1:0];
        end else if (stall_i) begin
            misalign_o    <= 1'b0;
        end else begin
            pc_word       <= pc_word + 30'd1;
            if_id_pc_o    <= imem_addr_o;
            if_id_pc4_o   <= pc_plus4;
            if_id_instr_o <= imem_instr_i;
            if_id_valid_o <= 1'b1;
            misalign_o    <= 1'b0;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Saturating event counters; they stick at all-ones rather than wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_o <= '0;
            perf_stall_o <= '0;
            perf_flush_o <= '0;
        end else if (redirect_i) begin
            if (perf_flush_o != '1) perf_flush_o <= perf_flush_o + CNT_W'(1);
        end else if (stall_i) begin
            if (perf_stall_o != '1) perf_stall_o <= perf_stall_o + CNT_W'(1);
        end else begin
            if (perf_fetch_o != '1) perf_fetch_o <= perf_fetch_o + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a spec-level model checked every cycle plus literal spot checks.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int          CW  = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] target = 32'h0;
    logic [31:0] imem_addr, imem_instr;
    logic [31:0] if_pc, if_pc4, if_instr;
    logic        if_valid, misalign;
`ifdef FETCH_PERF_CNT_EN
    logic [CW-1:0] perf_fetch, perf_stall, perf_flush;
`endif

    logic [31:0] mem [64];
    assign imem_instr = mem[imem_addr[7:2]];

    int tests = 0;
    int fails = 0;

    fetch_stage #(.RESET_PC(32'h0), .NOP_INSTR(NOP), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .stall_i(stall), .redirect_i(redirect),
        .redirect_target_i(target), .imem_addr_o(imem_addr), .imem_instr_i(imem_instr),
        .if_id_pc_o(if_pc), .if_id_pc4_o(if_pc4), .if_id_instr_o(if_instr),
        .if_id_valid_o(if_valid), .misalign_o(misalign)
`ifdef FETCH_PERF_CNT_EN
        , .perf_fetch_o(perf_fetch), .perf_stall_o(perf_stall), .perf_flush_o(perf_flush)
`endif
    );

    // Clock / reset
    always #5 clk = ~clk;

    // Behavioural model: what IF/ID must hold after each edge.
    logic [31:0] m_pc, m_ifpc, m_ifpc4, m_instr;
    logic        m_valid, m_mis;
    logic [CW-1:0] m_fetch, m_stall, m_flush;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc <= 32'h0; m_ifpc <= 32'h0; m_ifpc4 <= 32'h0;
            m_instr <= NOP; m_valid <= 1'b0; m_mis <= 1'b0;
            m_fetch <= '0; m_stall <= '0; m_flush <= '0;
        end else if (redirect) begin
            m_pc    <= target & ~32'd3;
            m_instr <= NOP;
            m_valid <= 1'b0;
            m_mis   <= (target % 4) != 0;
            if (m_flush != '1) m_flush <= m_flush + 1;
        end else if (stall) begin
            m_mis <= 1'b0;
            if (m_stall != '1) m_stall <= m_stall + 1;
        end else begin
            m_ifpc  <= m_pc;
            m_ifpc4 <= m_pc + 32'd4;
            m_instr <= mem[(m_pc / 4) % 64];
            m_valid <= 1'b1;
            m_mis   <= 1'b0;
            m_pc    <= m_pc + 32'd4;
            if (m_fetch != '1) m_fetch <= m_fetch + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard compare process: every negedge, DUT vs model.
    always @(negedge clk) begin
        chk("imem_addr", imem_addr, m_pc);
        chk("if_id_pc", if_pc, m_ifpc);
        chk("if_id_pc4", if_pc4, m_ifpc4);
        chk("if_id_instr", if_instr, m_instr);
        chk("if_id_valid", {31'h0, if_valid}, {31'h0, m_valid});
        chk("misalign", {31'h0, misalign}, {31'h0, m_mis});
`ifdef FETCH_PERF_CNT_EN
        chk("perf_fetch", perf_fetch, m_fetch);
        chk("perf_stall", perf_stall, m_stall);
        chk("perf_flush", perf_flush, m_flush);
`endif
    end

    // Driver: apply inputs at negedge, wait through one rising edge, return at negedge.
    task automatic step(input logic s, input logic r, input logic [31:0] t);
        stall = s; redirect = r; target = t;
        @(posedge clk);
        @(negedge clk);
        stall = 1'b0; redirect = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_addr"}, imem_addr, 32'h0);
        chk({tag, "_pc"}, if_pc, 32'h0);
        chk({tag, "_pc4"}, if_pc4, 32'h0);
        chk({tag, "_instr"}, if_instr, NOP);
        chk({tag, "_valid"}, {31'h0, if_valid}, 32'h0);
        chk({tag, "_mis"}, {31'h0, misalign}, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        chk({tag, "_pf"}, perf_fetch, 32'h0);
        chk({tag, "_ps"}, perf_stall, 32'h0);
        chk({tag, "_pl"}, perf_flush, 32'h0);
`endif
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + i;
        mem[0] = 32'h00A0_0093;
        mem[1] = 32'h0190_0113;
        mem[7] = 32'h0080_03EF;

        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_vals("reset");
        rst_n = 1'b1;

        // Straight-line fetch
        step(0, 0, 0);
        chk("e1_pc", if_pc, 32'h0);
        chk("e1_instr", if_instr, 32'h00A0_0093);
        chk("e1_valid", {31'h0, if_valid}, 32'h1);
        chk("e1_pc4", if_pc4, 32'h4);
        step(0, 0, 0);
        chk("e2_pc", if_pc, 32'h4);
        chk("e2_instr", if_instr, 32'h0190_0113);
        chk("e2_addr", imem_addr, 32'h8);

        // Stall for three edges with imem_addr at 0x0C
        step(0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0);
            chk("stall_addr", imem_addr, 32'h0C);
            chk("stall_pc", if_pc, 32'h08);
        end
        step(0, 0, 0);
        chk("unstall_pc", if_pc, 32'h0C);

        // Branch redirect from 0x18 to 0x1C
        step(0, 0, 0);
        step(0, 0, 0);
        chk("pre_br_addr", imem_addr, 32'h18);
        step(0, 1, 32'h1C);
        chk("br_valid", {31'h0, if_valid}, 32'h0);
        chk("br_instr", if_instr, NOP);
        chk("br_addr", imem_addr, 32'h1C);
        chk("br_keep_pc", if_pc, 32'h14);
        step(0, 0, 0);
        chk("br_tgt_pc", if_pc, 32'h1C);
        chk("br_tgt_instr", if_instr, 32'h0080_03EF);

        // Redirect and stall together: redirect wins
        step(1, 1, 32'h24);
        chk("rs_addr", imem_addr, 32'h24);
        chk("rs_valid", {31'h0, if_valid}, 32'h0);

        // Misaligned target: one-cycle pulse
        step(0, 1, 32'h26);
        chk("mis_addr", imem_addr, 32'h24);
        chk("mis_pulse", {31'h0, misalign}, 32'h1);
        step(0, 0, 0);
        chk("mis_clear", {31'h0, misalign}, 32'h0);

        // Back-to-back redirects: last one wins
        step(0, 1, 32'h40);
        step(0, 1, 32'h80);
        chk("b2b_addr", imem_addr, 32'h80);

        // Wrap past the top of the address space
        step(0, 1, 32'hFFFF_FFFE);
        chk("top_addr", imem_addr, 32'hFFFF_FFFC);
        chk("top_mis", {31'h0, misalign}, 32'h1);
        step(0, 0, 0);
        chk("wrap_addr", imem_addr, 32'h0);
        chk("wrap_pc", if_pc, 32'hFFFF_FFFC);
        chk("wrap_pc4", if_pc4, 32'h0);

        // Async reset between edges, right after a misaligned redirect
        stall = 1'b1; redirect = 1'b1; target = 32'h31;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("async");
        stall = 1'b0; redirect = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 0, 0);
        chk("post_rst_pc", if_pc, 32'h0);
        chk("post_rst_instr", if_instr, 32'h00A0_0093);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage of the 5-stage RV32I pipeline. Owns the program counter and drives the word address into the combinational instruction memory.
- Captures the returned instruction into the IF/ID pipeline register for the decode stage.
- Honours load-use stalls from the hazard unit and control-flow redirects (taken branch, JAL/JALR) resolved in EX. Wrong-path instructions are squashed by replacing them with NOP bubbles.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0) written into IF/ID on flush and reset.
- CNT_W, 32, width of each performance counter (used only with FETCH_PERF_CNT_EN).

Ports:
- clk  input  1  pipeline clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- stall_i  input  1  hazard unit holds PC and IF/ID (load-use).
- redirect_i  input  1  EX resolved a taken branch or jump this cycle.
- redirect_target_i  input  32  target PC for redirect.
- imem_addr_o  output  32  byte address to instruction memory; equals current PC.
- imem_instr_i  input  32  instruction word returned combinationally for imem_addr_o.
- if_id_pc_o  output  32  PC of the instruction in IF/ID.
- if_id_pc4_o  output  32  if_id_pc_o + 4 (JAL/JALR link value).
- if_id_instr_o  output  32  instruction in IF/ID.
- if_id_valid_o  output  1  1 = real instruction; 0 = bubble.
- misalign_o  output  1  one-cycle pulse: redirect target had nonzero bits [1:0].

Behaviour:
- Reset (rst_n low, asynchronous) forces and holds:
  - pc = RESET_PC
  - if_id_pc_o = 0
  - if_id_pc4_o = 0
  - if_id_instr_o = NOP_INSTR
  - if_id_valid_o = 0
  - misalign_o = 0
- First edge after reset release: IF/ID captures the instruction at RESET_PC, and pc becomes RESET_PC+4.
- imem_addr_o = pc, combinational; there is no registered address. Fetch latency: the instruction appears on if_id_* one edge after its PC is presented.
- Per-edge update, in priority order:
  1. redirect_i=1:
     - pc <= {redirect_target_i[31:2],2'b00}.
     - IF/ID <= bubble (instr=NOP_INSTR, valid=0, pc/pc4 keep old values).
     - misalign_o <= |redirect_target_i[1:0].
     - Redirect overrides stall_i in the same cycle, because the stalled instruction is younger than the branch and therefore on the wrong path.
  2. stall_i=1 (no redirect): pc and all IF/ID fields hold; misalign_o <= 0.
  3. Otherwise:
     - pc <= pc+4.
     - IF/ID <= {pc, pc+4, imem_instr_i, valid=1}.
     - misalign_o <= 0.
- Redirect penalty: in EX-resolved control flow, the instruction in IF/ID at the redirect edge is already flushed by the decode-side flush; this block flushes only the instruction currently being fetched. Net penalty: 2 bubbles total, of which 1 is produced here.
- Arithmetic: pc+4 is a 32-bit modular add. PC 32'hFFFF_FFFC advances to 32'h0000_0000 with no flag.
- The PC is always word-aligned internally; bits [1:0] of pc are constant 0.
- Back-to-back redirects: each one is honoured, and the last edge wins. There is no queueing.
- Stall held for N cycles: IF/ID stays stable for all N cycles; imem_addr_o stays constant.
- Reset asserted mid-stall or mid-redirect: pending state is discarded and outputs return to reset values immediately (asynchronous).

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- When defined, the block adds three CNT_W-bit outputs, all reset to 0 by rst_n:
  - perf_fetch_o: increments on every edge where IF/ID loads a valid instruction.
  - perf_stall_o: increments on every edge with stall_i=1 and redirect_i=0.
  - perf_flush_o: increments on every edge with redirect_i=1.
- The counters saturate at all-ones and do not wrap.
- When the macro is undefined, the ports and logic are absent and the port list is exactly the one above.

Test Plan:
- Reset/straight-line: release rst_n with memory holding 0x00A00093, 0x01900113 at 0x00/0x04 → edge1: if_id_pc=0x00, instr=0x00A00093, valid=1, pc4=0x04; edge2: if_id_pc=0x04, instr=0x01900113; imem_addr=0x08.
- Stall: assert stall_i for 3 cycles while imem_addr=0x0C → imem_addr stays 0x0C and IF/ID holds pc=0x08 for 3 edges; after deassert, IF/ID gets pc=0x0C.
- Branch redirect: at imem_addr=0x18 pulse redirect_i with target 0x1C → next edge IF/ID valid=0, instr=0x00000013, imem_addr=0x1C; following edge IF/ID pc=0x1C, instr=0x008003EF.
- Redirect+stall same cycle: stall_i=1, redirect_i=1, target 0x24 → pc=0x24, IF/ID bubble; stall ignored.
- Misaligned target 0x26 → pc=0x24, misalign_o=1 for exactly one cycle, then 0.
- Wrap and async reset: force pc=0xFFFFFFFC via redirect → next pc=0x00000000. Then drop rst_n between edges → outputs return to reset values before the next rising edge. With FETCH_PERF_CNT_EN defined, perf counters also read 0.
